// File: rtl/axis_pipe_gen.sv
// Parametrised AXI-Stream register chain: skid, simple or bypass stages, with occupancy and idle.
// Define AXIS_PIPE_PARITY_EN to add per-beat parity, inj_par_err and a sticky parity_err.
module axis_pipe_gen #(
  parameter int unsigned  NUM_PIPELINES  = 1,
  parameter int unsigned  MODE           = 0,
  parameter bit           TREADY_RST_VAL = 1'b0,
  parameter int unsigned  TDATA_WIDTH    = 512,
  parameter int unsigned  TUSER_WIDTH    = 10,
  parameter bit           ENABLE_TKEEP   = 1'b1,
  localparam int unsigned OCC_W          = $clog2(2 * NUM_PIPELINES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                     s_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  output logic [OCC_W-1:0]         occupancy,
  output logic                     idle
`ifdef AXIS_PIPE_PARITY_EN
  ,
  input  logic                     inj_par_err,
  output logic                     parity_err
`endif
);

  localparam int unsigned KW = TDATA_WIDTH / 8;
  localparam int unsigned DW = TDATA_WIDTH + KW + TUSER_WIDTH + 1;
`ifdef AXIS_PIPE_PARITY_EN
  localparam int unsigned PW = DW + 1;
`else
  localparam int unsigned PW = DW;
`endif

  // Index k is the s side of stage k; index NUM_PIPELINES is the chain's m side.
  logic [NUM_PIPELINES:0] w_valid;
  logic [NUM_PIPELINES:0] w_ready;
  logic [PW-1:0]          w_data [NUM_PIPELINES+1];

  logic [KW-1:0] w_s_keep;
  logic [DW-1:0] w_s_beat;
  logic [DW-1:0] w_m_beat;
  logic          w_s_fire;
  logic          w_m_fire;

  assign w_s_keep = ENABLE_TKEEP ? s_tkeep : '1;
  assign w_s_beat = {s_tdata, w_s_keep, s_tuser, s_tlast};
`ifdef AXIS_PIPE_PARITY_EN
  assign w_data[0] = {(^w_s_beat) ^ inj_par_err, w_s_beat};
`else
  assign w_data[0] = w_s_beat;
`endif

  assign w_valid[0]             = s_tvalid;
  assign w_ready[NUM_PIPELINES] = m_tready;
  assign w_m_beat               = w_data[NUM_PIPELINES][DW-1:0];

  assign s_tready = rst_n ? w_ready[0] : TREADY_RST_VAL;
  assign m_tvalid = w_valid[NUM_PIPELINES];
  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = w_m_beat;

  assign w_s_fire = s_tvalid && s_tready;
  assign w_m_fire = m_tvalid && m_tready;

  for (genvar k = 0; k < NUM_PIPELINES; k++) begin : g_stage
    if (MODE == 0) begin : g_skid
      logic          r_main_vld;
      logic          r_skid_vld;
      logic          r_rdy;
      logic [PW-1:0] r_main;
      logic [PW-1:0] r_skid;
      logic          w_in_fire;
      logic          w_main_free;
      logic          w_main_vld_d;
      logic          w_skid_vld_d;

      assign w_in_fire   = w_valid[k] && r_rdy;
      assign w_main_free = !r_main_vld || w_ready[k+1];

      // r_rdy mirrors !skid_vld, so an accept never coincides with a full skid.
      always_comb begin
        w_main_vld_d = 1'b1;
        w_skid_vld_d = 1'b0;
        if (w_main_free) begin
          w_main_vld_d = r_skid_vld || w_in_fire;
        end else begin
          w_skid_vld_d = r_skid_vld || w_in_fire;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_vld <= 1'b0;
          r_skid_vld <= 1'b0;
          r_rdy      <= TREADY_RST_VAL;
        end else begin
          r_main_vld <= w_main_vld_d;
          r_skid_vld <= w_skid_vld_d;
          r_rdy      <= !w_skid_vld_d;
        end
      end

      always_ff @(posedge clk) begin
        if (w_main_free) begin
          if (r_skid_vld) begin
            r_main <= r_skid;
          end else if (w_in_fire) begin
            r_main <= w_data[k];
          end
        end else if (w_in_fire) begin
          r_skid <= w_data[k];
        end
      end

      assign w_ready[k]   = r_rdy;
      assign w_valid[k+1] = r_main_vld;
      assign w_data[k+1]  = r_main;
    end else if (MODE == 1) begin : g_simple
      logic          r_vld;
      logic [PW-1:0] r_data;
      logic          w_rdy;

      assign w_rdy = !r_vld || w_ready[k+1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
        end else if (w_rdy) begin
          r_vld <= w_valid[k];
        end
      end

      always_ff @(posedge clk) begin
        if (w_rdy && w_valid[k]) begin
          r_data <= w_data[k];
        end
      end

      assign w_ready[k]   = w_rdy;
      assign w_valid[k+1] = r_vld;
      assign w_data[k+1]  = r_data;
    end else begin : g_bypass
      assign w_ready[k]   = w_ready[k+1];
      assign w_valid[k+1] = w_valid[k];
      assign w_data[k+1]  = w_data[k];
    end
  end

  if (MODE == 2) begin : g_occ_bypass
    assign occupancy = '0;
  end else begin : g_occ
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_d;

    always_comb begin
      w_occ_d = r_occ;
      if (w_s_fire && !w_m_fire) begin
        w_occ_d = r_occ + OCC_W'(1);
      end else if (!w_s_fire && w_m_fire) begin
        w_occ_d = r_occ - OCC_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_occ <= '0;
      end else begin
        r_occ <= w_occ_d;
      end
    end

    assign occupancy = r_occ;
  end

  assign idle = (occupancy == '0) && !s_tvalid;

`ifdef AXIS_PIPE_PARITY_EN
  logic w_par_bad;
  logic r_parity_err;

  // Stored bit plus payload XOR to zero for an intact beat.
  assign w_par_bad = ^w_data[NUM_PIPELINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_m_fire && w_par_bad) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_axis_pipe_gen.sv
// Bench for axis_pipe_gen: four instances (skid x2, simple, bypass) checked against
// a per-instance FIFO model of accepted beats; parity cases run when AXIS_PIPE_PARITY_EN is set.
module tb_axis_pipe_gen;

  localparam int unsigned NI = 4;
  typedef logic [40:0] beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [NI];
  logic        s_tvalid [NI];
  logic        s_tready [NI];
  logic [31:0] s_tdata  [NI];
  logic [3:0]  s_tkeep  [NI];
  logic        s_tlast  [NI];
  logic [3:0]  s_tuser  [NI];
  logic        m_tvalid [NI];
  logic        m_tready [NI];
  logic [31:0] m_tdata  [NI];
  logic [3:0]  m_tkeep  [NI];
  logic        m_tlast  [NI];
  logic [3:0]  m_tuser  [NI];
  logic        idle     [NI];
  logic [3:0]  occ      [NI];
  logic [2:0]  occ0;
  logic [2:0]  occ1;
  logic [3:0]  occ2;
  logic [1:0]  occ3;
`ifdef AXIS_PIPE_PARITY_EN
  logic        inj      [NI];
  logic        perr     [NI];
`endif

  assign occ[0] = {1'b0, occ0};
  assign occ[1] = {1'b0, occ1};
  assign occ[2] = occ2;
  assign occ[3] = {2'b00, occ3};

  axis_pipe_gen #(.NUM_PIPELINES(3), .MODE(0), .TREADY_RST_VAL(1'b1), .TDATA_WIDTH(32),
                  .TUSER_WIDTH(4), .ENABLE_TKEEP(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]),
    .s_tdata(s_tdata[0]), .s_tkeep(s_tkeep[0]), .s_tlast(s_tlast[0]), .s_tuser(s_tuser[0]),
    .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]),
    .m_tkeep(m_tkeep[0]), .m_tlast(m_tlast[0]), .m_tuser(m_tuser[0]),
    .occupancy(occ0), .idle(idle[0])
`ifdef AXIS_PIPE_PARITY_EN
    , .inj_par_err(inj[0]), .parity_err(perr[0])
`endif
  );

  axis_pipe_gen #(.NUM_PIPELINES(2), .MODE(0), .TREADY_RST_VAL(1'b0), .TDATA_WIDTH(32),
                  .TUSER_WIDTH(4), .ENABLE_TKEEP(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]),
    .s_tdata(s_tdata[1]), .s_tkeep(s_tkeep[1]), .s_tlast(s_tlast[1]), .s_tuser(s_tuser[1]),
    .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]),
    .m_tkeep(m_tkeep[1]), .m_tlast(m_tlast[1]), .m_tuser(m_tuser[1]),
    .occupancy(occ1), .idle(idle[1])
`ifdef AXIS_PIPE_PARITY_EN
    , .inj_par_err(inj[1]), .parity_err(perr[1])
`endif
  );

  axis_pipe_gen #(.NUM_PIPELINES(4), .MODE(1), .TREADY_RST_VAL(1'b0), .TDATA_WIDTH(32),
                  .TUSER_WIDTH(4), .ENABLE_TKEEP(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .s_tvalid(s_tvalid[2]), .s_tready(s_tready[2]),
    .s_tdata(s_tdata[2]), .s_tkeep(s_tkeep[2]), .s_tlast(s_tlast[2]), .s_tuser(s_tuser[2]),
    .m_tvalid(m_tvalid[2]), .m_tready(m_tready[2]), .m_tdata(m_tdata[2]),
    .m_tkeep(m_tkeep[2]), .m_tlast(m_tlast[2]), .m_tuser(m_tuser[2]),
    .occupancy(occ2), .idle(idle[2])
`ifdef AXIS_PIPE_PARITY_EN
    , .inj_par_err(inj[2]), .parity_err(perr[2])
`endif
  );

  axis_pipe_gen #(.NUM_PIPELINES(1), .MODE(2), .TREADY_RST_VAL(1'b0), .TDATA_WIDTH(32),
                  .TUSER_WIDTH(4), .ENABLE_TKEEP(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n[3]), .s_tvalid(s_tvalid[3]), .s_tready(s_tready[3]),
    .s_tdata(s_tdata[3]), .s_tkeep(s_tkeep[3]), .s_tlast(s_tlast[3]), .s_tuser(s_tuser[3]),
    .m_tvalid(m_tvalid[3]), .m_tready(m_tready[3]), .m_tdata(m_tdata[3]),
    .m_tkeep(m_tkeep[3]), .m_tlast(m_tlast[3]), .m_tuser(m_tuser[3]),
    .occupancy(occ3), .idle(idle[3])
`ifdef AXIS_PIPE_PARITY_EN
    , .inj_par_err(inj[3]), .parity_err(perr[3])
`endif
  );

  // Reference model: every accepted beat in acceptance order, not yet seen on the m side.
  beat_t sb_mem  [NI][64];
  int    sb_head [NI];
  int    sb_tail [NI];
  int    n_acc   [NI];
  int    n_out   [NI];
  logic  acc     [NI];
  logic  outp    [NI];
  logic  rdy_seen[NI];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;

  function automatic beat_t pack(input logic [31:0] d, input logic [3:0] k, input logic [3:0] u,
                                 input logic l);
    return {d, k, u, l};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle, update the model, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      int cnt;
      cnt = sb_tail[i] - sb_head[i];
      chk($sformatf("occ%0d", i), 64'(occ[i]), 64'(cnt));
      chk($sformatf("idle%0d", i), 64'(idle[i]), 64'((cnt == 0) && !s_tvalid[i]));
      rdy_seen[i] = s_tready[i];
      acc[i]  = rst_n[i] && s_tvalid[i] && s_tready[i];
      outp[i] = m_tvalid[i] && m_tready[i];
      if (acc[i]) begin
        sb_mem[i][sb_tail[i] % 64] = pack(s_tdata[i], s_tkeep[i], s_tuser[i], s_tlast[i]);
        sb_tail[i]++;
        n_acc[i]++;
      end
      if (outp[i]) begin
        if (sb_tail[i] == sb_head[i]) begin
          chk($sformatf("sb_extra%0d", i), 64'(m_tvalid[i]), 64'(0));
        end else begin
          chk($sformatf("sb_beat%0d", i), 64'(pack(m_tdata[i], m_tkeep[i], m_tuser[i],
              m_tlast[i])), 64'(sb_mem[i][sb_head[i] % 64]));
          sb_head[i]++;
        end
        n_out[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i, input int budget);
    int guard;
    guard = 0;
    while (sb_tail[i] != sb_head[i] && guard < budget) begin
      step();
      guard++;
    end
    chk($sformatf("drain_timeout%0d", i), 64'(sb_tail[i] - sb_head[i]), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; s_tvalid[i] = 1'b0; s_tdata[i] = '0; s_tkeep[i] = 4'hf;
      s_tlast[i] = 1'b0; s_tuser[i] = '0; m_tready[i] = 1'b0;
      sb_head[i] = 0; sb_tail[i] = 0; n_acc[i] = 0; n_out[i] = 0;
      acc[i] = 1'b0; outp[i] = 1'b0; rdy_seen[i] = 1'b0;
`ifdef AXIS_PIPE_PARITY_EN
      inj[i] = 1'b0;
`endif
    end

    // Reset values
    step();
    chk("rst_rdy0", 64'(s_tready[0]), 64'(1));
    chk("rst_rdy1", 64'(s_tready[1]), 64'(0));
    chk("rst_rdy2", 64'(s_tready[2]), 64'(0));
    chk("rst_rdy3", 64'(s_tready[3]), 64'(0));
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_mvalid%0d", i), 64'(m_tvalid[i]), 64'(0));
      chk($sformatf("rst_idle%0d", i), 64'(idle[i]), 64'(1));
    end
    step();
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    step();
    step();

    // MODE 0, 3 stages, continuous ready: 100 back-to-back beats
    begin
      int idx, first_acc, first_out, last_out, base_out, guard;
      idx = 0; first_acc = -1; first_out = -1; last_out = -1; base_out = n_out[0]; guard = 0;
      m_tready[0] = 1'b1;
      while (idx < 100 && guard < 400) begin
        s_tvalid[0] = 1'b1; s_tdata[0] = 32'(idx); s_tkeep[0] = 4'hf;
        s_tuser[0] = 4'(idx); s_tlast[0] = (idx == 99);
        step();
        guard++;
        if (outp[0]) begin
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
        end
        if (acc[0]) begin
          if (first_acc < 0) first_acc = cyc;
          idx++;
          if (idx == 50) chk("a_occ_steady", 64'(occ[0]), 64'(3));
        end
      end
      s_tvalid[0] = 1'b0;
      guard = 0;
      while (sb_tail[0] != sb_head[0] && guard < 20) begin
        step();
        guard++;
        if (outp[0]) last_out = cyc;
      end
      chk("a_latency", 64'(first_out - first_acc), 64'(3));
      chk("a_count", 64'(n_out[0] - base_out), 64'(100));
      chk("a_throughput", 64'(last_out - first_out), 64'(99));
      chk("a_idle", 64'(idle[0]), 64'(1));
    end

    // MODE 0, 2 stages, stalled sink: fills to 4 beats, then drains
    begin
      int base_acc, base_out;
      base_acc = n_acc[1]; base_out = n_out[1];
      m_tready[1] = 1'b0; s_tvalid[1] = 1'b1; s_tkeep[1] = 4'h5; s_tuser[1] = 4'h3;
      for (int k = 1; k <= 8; k++) begin
        s_tdata[1] = 32'h100 + 32'(n_acc[1]);
        s_tlast[1] = (n_acc[1] == 3);
        step();
        chk($sformatf("b_rdy_c%0d", k), 64'(rdy_seen[1]), 64'(k <= 4));
      end
      chk("b_acc", 64'(n_acc[1] - base_acc), 64'(4));
      chk("b_occ", 64'(occ[1]), 64'(4));
      s_tvalid[1] = 1'b0;
      m_tready[1] = 1'b1;
      drain(1, 20);
      step();
      chk("b_rdy_after", 64'(s_tready[1]), 64'(1));
      chk("b_out", 64'(n_out[1] - base_out), 64'(4));
    end

    // MODE 1, 4 stages, random valid/ready for 10k beats
    begin
      int guard;
      logic [3:0] maxocc;
      guard = 0; maxocc = '0;
      s_tvalid[2] = 1'b0;
      while (n_acc[2] < 10000 && guard < 60000) begin
        if (!s_tvalid[2] || acc[2]) begin
          s_tvalid[2] = 1'($urandom_range(0, 1));
          s_tdata[2]  = $urandom;
          s_tkeep[2]  = 4'($urandom);
          s_tuser[2]  = 4'($urandom);
          s_tlast[2]  = 1'($urandom);
        end
        m_tready[2] = 1'($urandom_range(0, 1));
        step();
        guard++;
        if (occ[2] > maxocc) maxocc = occ[2];
      end
      s_tvalid[2] = 1'b0;
      m_tready[2] = 1'b1;
      drain(2, 40);
      chk("c_beats_in", 64'(n_acc[2] >= 10000), 64'(1));
      chk("c_beats_out", 64'(n_out[2]), 64'(n_acc[2]));
      chk("c_occ_le4", 64'(maxocc <= 4), 64'(1));
      chk("c_idle", 64'(idle[2]), 64'(1));
    end

    // MODE 2: combinational pass-through
    for (int k = 0; k < 6; k++) begin
      s_tvalid[3] = 1'($urandom_range(0, 1)) | (k == 0);
      s_tdata[3]  = $urandom;
      s_tkeep[3]  = 4'($urandom);
      s_tuser[3]  = 4'($urandom);
      s_tlast[3]  = 1'($urandom);
      m_tready[3] = (k % 2 == 0);
      #1;
      chk("d_valid", 64'(m_tvalid[3]), 64'(s_tvalid[3]));
      chk("d_data", 64'(m_tdata[3]), 64'(s_tdata[3]));
      chk("d_keep", 64'(m_tkeep[3]), 64'(s_tkeep[3]));
      chk("d_user", 64'(m_tuser[3]), 64'(s_tuser[3]));
      chk("d_last", 64'(m_tlast[3]), 64'(s_tlast[3]));
      chk("d_rdy", 64'(s_tready[3]), 64'(k % 2 == 0));
      chk("d_occ", 64'(occ[3]), 64'(0));
      step();
    end
    s_tvalid[3] = 1'b0;

    // Reset mid-packet with 3 beats held, TREADY_RST_VAL = 1
    begin
      int idx, base_out, guard;
      m_tready[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s_tvalid[0] = 1'b1; s_tdata[0] = 32'hE0 + 32'(k); s_tlast[0] = 1'b0; s_tuser[0] = 4'(k);
        step();
      end
      chk("e_occ3", 64'(occ[0]), 64'(3));
      s_tdata[0] = 32'hBAD; m_tready[0] = 1'b1;
      rst_n[0] = 1'b0;
      #1;
      chk("e_mvalid", 64'(m_tvalid[0]), 64'(0));
      chk("e_occ0", 64'(occ[0]), 64'(0));
      chk("e_rdy", 64'(s_tready[0]), 64'(1));
      sb_head[0] = sb_tail[0];
      step();
      step();
      chk("e_rdy_hold", 64'(s_tready[0]), 64'(1));
      chk("e_mvalid_hold", 64'(m_tvalid[0]), 64'(0));
      rst_n[0] = 1'b1;
      s_tvalid[0] = 1'b0;
      base_out = n_out[0];
      step();
      idx = 0; guard = 0;
      while (idx < 4 && guard < 20) begin
        s_tvalid[0] = 1'b1; s_tdata[0] = 32'hC0 + 32'(idx); s_tuser[0] = 4'(idx + 8);
        s_tkeep[0] = 4'(idx + 1); s_tlast[0] = (idx == 3);
        step();
        guard++;
        if (acc[0]) idx++;
      end
      s_tvalid[0] = 1'b0;
      drain(0, 20);
      chk("e_out", 64'(n_out[0] - base_out), 64'(4));
      chk("e_idle", 64'(idle[0]), 64'(1));
    end

`ifdef AXIS_PIPE_PARITY_EN
    // Parity: corrupt beat 7 of 20 on instance 0, instance 1 stays clean
    begin
      int i0, i1, b0, b1, guard;
      b0 = n_out[0]; b1 = n_out[1]; i0 = 0; i1 = 0; guard = 0;
      m_tready[0] = 1'b1; m_tready[1] = 1'b1;
      while ((n_out[0] - b0 < 20 || n_out[1] - b1 < 20) && guard < 100) begin
        s_tvalid[0] = (i0 < 20); s_tdata[0] = 32'hF00 + 32'(i0); s_tlast[0] = (i0 == 19);
        inj[0] = (i0 == 7);
        s_tvalid[1] = (i1 < 20); s_tdata[1] = 32'hA00 + 32'(i1); s_tlast[1] = (i1 == 19);
        inj[1] = 1'b0;
        step();
        guard++;
        if (acc[0]) i0++;
        if (acc[1]) i1++;
        chk("f_perr_inj", 64'(perr[0]), 64'((n_out[0] - b0) > 7));
        chk("f_perr_clean", 64'(perr[1]), 64'(0));
      end
      inj[0] = 1'b0; s_tvalid[0] = 1'b0; s_tvalid[1] = 1'b0;
      step();
      chk("f_perr_sticky", 64'(perr[0]), 64'(1));
      chk("f_out0", 64'(n_out[0] - b0), 64'(20));
      chk("f_out1", 64'(n_out[1] - b1), 64'(20));
      chk("f_perr_mode1", 64'(perr[2]), 64'(0));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
